// File: rtl/pos_add_seq.sv
// -----------------------------------------------------------------------------
// pos_add_seq
// Sequencer for a shared one-hot (positional-encoded) base-8 digit adder.
// Two NDIG-digit one-hot operands are added one digit at a time through a
// single external adder; a carry into a digit is absorbed by an extra +1 pass
// through the same adder.
//
// Optional feature macro: OHCHK_EN (operand one-hot check, drives err).
//
// Ports
//   clk      in   1        clock, rising edge
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request, sampled only in IDLE
//   op_a     in   NDIG*8   operand A, one-hot digit per byte, digit 0 = [7:0]
//   op_b     in   NDIG*8   operand B, same encoding
//   busy     out  1        high from cycle after acceptance through DONE
//   done     out  1        one-cycle pulse, result/cout valid
//   result   out  NDIG*8   one-hot sum digits, held until next operation
//   cout     out  1        carry out of digit NDIG-1
//   err      out  1        operand encoding error (OHCHK_EN only, else 0)
//   add_en   out  1        adder enable
//   add_a    out  9        adder operand 1 (bit 8 always 0)
//   add_b    out  9        adder operand 2 (bit 8 always 0)
//   add_res  in   17       adder output, combinational in the same cycle:
//                          [9-k] = sum digit k, [1] = no carry, [0] = carry
// -----------------------------------------------------------------------------
module pos_add_seq #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NDIG*8-1:0] op_a,
   input  logic [NDIG*8-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [NDIG*8-1:0] result,
   output logic              cout,
   output logic              err,
   output logic              add_en,
   output logic [8:0]        add_a,
   output logic [8:0]        add_b,
   input  logic [16:0]       add_res
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_INC, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [NDIG*8-1:0]   r_a;
   logic [NDIG*8-1:0]   r_b;
   logic [NDIG*8-1:0]   r_result;
   logic [IW-1:0]       r_i;
   logic                r_c;     // carry into the current digit
   logic                r_c1;    // carry produced by the ADD pass of this digit
   logic                r_cout;
   logic [7:0]          w_sum_digit;
   logic                w_carry;
   logic                w_last;
   logic                w_bad;
   logic [7:0]          w_a_dig;
   logic [7:0]          w_b_dig;
   logic [7:0]          w_res_dig;
   logic                w_unused_bits;

   // The adder presents its sum digits bit-reversed in [9:2].
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_sum
         assign w_sum_digit[gi] = add_res[9-gi];
      end
   endgenerate

   assign w_carry       = add_res[0];
   assign w_unused_bits = ^{add_res[16:10], add_res[1]};
   assign w_last        = (r_i == IW'(NDIG-1));
   assign w_a_dig       = r_a[r_i*8 +: 8];
   assign w_b_dig       = r_b[r_i*8 +: 8];
   assign w_res_dig     = r_result[r_i*8 +: 8];

`ifdef OHCHK_EN
   logic r_bad;   // latched encoding error of the accepted operands
   logic r_err;
   logic w_ops_ok;

   always_comb begin
      w_ops_ok = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
         if (op_a[k*8 +: 8] == 8'd0 || (op_a[k*8 +: 8] & (op_a[k*8 +: 8] - 8'd1)) != 8'd0)
            w_ops_ok = 1'b0;
         if (op_b[k*8 +: 8] == 8'd0 || (op_b[k*8 +: 8] & (op_b[k*8 +: 8] - 8'd1)) != 8'd0)
            w_ops_ok = 1'b0;
      end
   end

   assign w_bad = r_bad;
   assign err   = r_err;
`else
   assign w_bad = 1'b0;
   assign err   = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_next = S_ADD;
         S_ADD: begin
            // A flagged operand pair skips the adder entirely.
            if (w_bad)       w_state_next = S_DONE;
            else if (r_c)    w_state_next = S_INC;
            else if (w_last) w_state_next = S_DONE;
         end
         S_INC:   w_state_next = w_last ? S_DONE : S_ADD;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy   = (r_state != S_IDLE);
      done   = (r_state == S_DONE);
      add_en = 1'b0;
      add_a  = 9'd0;
      add_b  = 9'd0;
      case (r_state)
         S_ADD: begin
            add_en = ~w_bad;
            add_a  = {1'b0, w_a_dig};
            add_b  = {1'b0, w_b_dig};
         end
         S_INC: begin
            add_en = 1'b1;
            add_a  = {1'b0, w_res_dig};
            add_b  = 9'b0_0000_0010;
         end
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_i      <= '0;
         r_c      <= 1'b0;
         r_c1     <= 1'b0;
         r_cout   <= 1'b0;
`ifdef OHCHK_EN
         r_bad    <= 1'b0;
         r_err    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_a  <= op_a;
               r_b  <= op_b;
               r_i  <= '0;
               r_c  <= 1'b0;
               r_c1 <= 1'b0;
`ifdef OHCHK_EN
               r_bad <= ~w_ops_ok;
               r_err <= 1'b0;
`endif
            end
            S_ADD: if (!w_bad) begin
               r_result[r_i*8 +: 8] <= w_sum_digit;
               r_c1                 <= w_carry;
               // With a pending carry-in the digit index holds for the INC pass.
               if (!r_c) begin
                  r_c <= w_carry;
                  if (w_last) r_cout <= w_carry;
                  else        r_i    <= r_i + 1'b1;
               end
            end else begin
`ifdef OHCHK_EN
               r_err <= 1'b1;
`endif
            end
            S_INC: begin
               r_result[r_i*8 +: 8] <= w_sum_digit;
               // The two passes can never both carry, so OR is the true carry.
               r_c <= r_c1 | w_carry;
               if (w_last) r_cout <= r_c1 | w_carry;
               else        r_i    <= r_i + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign cout   = r_cout;

endmodule

// File: tb/tb_pos_add_seq.sv
module tb_pos_add_seq;

   localparam int NDIG = 4;
   localparam int W    = NDIG*8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  op_a, op_b;
   logic          busy, done, cout, err, add_en;
   logic [W-1:0]  result;
   logic [8:0]    add_a, add_b;
   logic [16:0]   add_res;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pos_add_seq #(.NDIG(NDIG)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .cout(cout), .err(err),
      .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_res(add_res)
   );

   // External one-hot adder: every pair of set input bits contributes its
   // sum digit (OR-merged); silent when not enabled.
   always_comb begin
      add_res = 17'd0;
      if (add_en) begin
         for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++)
               if (add_a[j] && add_b[k]) begin
                  add_res[9-((j+k)%8)] = 1'b1;
                  if (j+k >= 8) add_res[0] = 1'b1;
                  else          add_res[1] = 1'b1;
               end
      end
   end

   function automatic logic [W-1:0] enc(input int d3, input int d2, input int d1, input int d0);
      logic [W-1:0] v;
      v = '0;
      v[d0]      = 1'b1;
      v[8+d1]    = 1'b1;
      v[16+d2]   = 1'b1;
      v[24+d3]   = 1'b1;
      return v;
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < NDIG; i++) v[i*8 + $urandom_range(0,7)] = 1'b1;
      return v;
   endfunction

   function automatic int dig_val(input logic [7:0] d);
      for (int k = 0; k < 8; k++) if (d[k]) return k;
      return 0;
   endfunction

   // Reference: integer addition of the base-8 values.
   function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic co, output int lat);
      longint va, vb, tot, m;
      int     n_inc;
      va = 0; vb = 0; n_inc = 0;
      for (int i = 0; i < NDIG; i++) begin
         va += longint'(dig_val(a[i*8 +: 8])) << (3*i);
         vb += longint'(dig_val(b[i*8 +: 8])) << (3*i);
      end
      for (int i = 1; i < NDIG; i++) begin
         m = longint'(1) << (3*i);
         if ((va % m) + (vb % m) >= m) n_inc++;
      end
      tot = va + vb;
      r = '0;
      for (int i = 0; i < NDIG; i++) r[i*8 + int'((tot >> (3*i)) & 7)] = 1'b1;
      co  = ((tot >> (3*NDIG)) & 1) != 0;
      lat = NDIG + 1 + n_inc;
   endfunction

   // Runs one operation and reports what was observed; p1/p2 are cycles in
   // which start is pulsed while the operation is in flight (0 = none).
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int p1, input int p2,
                        output int lat, output logic [W-1:0] res, output logic co, output logic er,
                        output int en_cnt, output int done_cnt, output int busy_bad);
      lat = 0; en_cnt = 0; done_cnt = 0; busy_bad = 0; res = '0; co = 1'b0; er = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op_a = a; op_b = b;
      @(posedge clk); #1;
      start = 1'b0; op_a = $urandom; op_b = $urandom;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (lat == 0 && busy !== 1'b1) busy_bad++;
         if (lat != 0 && busy !== 1'b0) busy_bad++;
         if (add_en === 1'b1) en_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (lat == 0) begin lat = k; res = result; co = cout; er = err; end
         end
         start = (k == p1 || k == p2) ? 1'b1 : 1'b0;
         if (lat != 0 && k >= lat + 3) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1;
      op_a = enc(0,1,2,3); op_b = enc(0,2,3,4);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, cout, err, add_en, result, add_a, add_b} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b cout=%b err=%b add_en=%b result=%h add_a=%h add_b=%h want all 0",
                  busy, done, cout, err, add_en, result, add_a, add_b);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_accept got busy=%b want 1", busy);
      end
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
         end
         checks++;
         if (seen != 1) begin
            errors++;
            $display("FAIL reset_first_done got no done want done");
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_directed();
      logic [W-1:0] va[3], vb[3];
      va[0] = enc(0,1,2,3); vb[0] = enc(0,2,3,4);
      va[1] = enc(7,7,7,7); vb[1] = enc(0,0,0,1);
      va[2] = enc(0,3,5,6); vb[2] = enc(0,4,2,2);
      for (int t = 0; t < 3; t++) begin
         logic [W-1:0] er_res, ob_res;
         logic er_co, ob_co, ob_err;
         int er_lat, ob_lat, en_cnt, dcnt, bbad;
         ref_add(va[t], vb[t], er_res, er_co, er_lat);
         do_op(va[t], vb[t], 0, 0, ob_lat, ob_res, ob_co, ob_err, en_cnt, dcnt, bbad);
         checks++;
         if (ob_res !== er_res || ob_co !== er_co) begin
            errors++;
            $display("FAIL dir%0d_sum got result=%h cout=%b want result=%h cout=%b", t, ob_res, ob_co, er_res, er_co);
         end
         checks++;
         if (ob_lat != er_lat || dcnt != 1) begin
            errors++;
            $display("FAIL dir%0d_latency got done_cycle=%0d done_count=%0d want %0d and 1", t, ob_lat, dcnt, er_lat);
         end
         checks++;
         if (en_cnt != er_lat - 1 || bbad != 0 || ob_err !== 1'b0) begin
            errors++;
            $display("FAIL dir%0d_ctrl got add_en_cycles=%0d busy_bad=%0d err=%b want %0d 0 0", t, en_cnt, bbad, ob_err, er_lat-1);
         end
         $display("dir%0d a=%h b=%h result=%h cout=%b done_cycle=%0d", t, va[t], vb[t], ob_res, ob_co, ob_lat);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 24; t++) begin
         logic [W-1:0] a, b, er_res, ob_res;
         logic er_co, ob_co, ob_err;
         int er_lat, ob_lat, en_cnt, dcnt, bbad;
         a = rand_op(); b = rand_op();
         ref_add(a, b, er_res, er_co, er_lat);
         do_op(a, b, 0, 0, ob_lat, ob_res, ob_co, ob_err, en_cnt, dcnt, bbad);
         checks++;
         if (ob_res !== er_res || ob_co !== er_co || ob_lat != er_lat || dcnt != 1 || en_cnt != er_lat - 1) begin
            errors++;
            $display("FAIL rand%0d got result=%h cout=%b cycle=%0d dones=%0d en=%0d want result=%h cout=%b cycle=%0d dones=1 en=%0d",
                     t, ob_res, ob_co, ob_lat, dcnt, en_cnt, er_res, er_co, er_lat, er_lat-1);
         end
         $display("rand%0d a=%h b=%h result=%h cout=%b done_cycle=%0d", t, a, b, ob_res, ob_co, ob_lat);
      end
   endtask

   task automatic test_busy_start();
      logic [W-1:0] a, b, er_res, ob_res;
      logic er_co, ob_co, ob_err;
      int er_lat, ob_lat, en_cnt, dcnt, bbad;
      a = enc(0,1,2,3); b = enc(0,2,3,4);
      ref_add(a, b, er_res, er_co, er_lat);
      do_op(a, b, 2, 5, ob_lat, ob_res, ob_co, ob_err, en_cnt, dcnt, bbad);
      checks++;
      if (dcnt != 1 || ob_lat != er_lat || bbad != 0) begin
         errors++;
         $display("FAIL busy_start_ignored got dones=%0d cycle=%0d busy_bad=%0d want 1 %0d 0", dcnt, ob_lat, bbad, er_lat);
      end
      checks++;
      if (ob_res !== er_res || result !== er_res) begin
         errors++;
         $display("FAIL busy_start_result got %h/%h want %h", ob_res, result, er_res);
      end
      $display("busy_start result=%h dones=%0d done_cycle=%0d", ob_res, dcnt, ob_lat);
   endtask

   task automatic test_midreset();
      int seen;
      @(posedge clk); #1;
      start = 1'b1; op_a = enc(7,7,7,7); op_b = enc(0,0,0,1);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (result !== '0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || add_en !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear got result=%h cout=%b busy=%b done=%b add_en=%b want all 0",
                  result, cout, busy, done, add_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || result !== '0) begin
         errors++;
         $display("FAIL midreset_no_done got active_cycles=%0d result=%h want 0 and 0", seen, result);
      end
      $display("midreset result=%h cout=%b", result, cout);
   endtask

`ifdef OHCHK_EN
   task automatic test_ohchk();
      logic [W-1:0] a, ob_res, prev;
      logic ob_co, ob_err, prev_co;
      int ob_lat, en_cnt, dcnt, bbad;
      prev = result; prev_co = cout;
      a = enc(0,1,2,3); a[7:0] = 8'h03;
      do_op(a, enc(0,2,3,4), 0, 0, ob_lat, ob_res, ob_co, ob_err, en_cnt, dcnt, bbad);
      checks++;
      if (ob_lat != 2 || ob_err !== 1'b1 || en_cnt != 0 || ob_res !== prev || ob_co !== prev_co) begin
         errors++;
         $display("FAIL ohchk got cycle=%0d err=%b en=%0d result=%h cout=%b want 2 1 0 %h %b",
                  ob_lat, ob_err, en_cnt, ob_res, ob_co, prev, prev_co);
      end
      $display("ohchk err=%b done_cycle=%0d", ob_err, ob_lat);
   endtask
`endif

   initial begin
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
      test_reset();
      test_directed();
      test_random();
      test_busy_start();
      test_midreset();
`ifdef OHCHK_EN
      test_ohchk();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
